// File: rtl/mna_pkg.sv
// Shared definitions for the multi-nibble sequential adder.
// Holds the nibble width, FSM state type and index width helper.
package mna_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index counter for n slices (n >= 2).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_nibble_add_seq.sv
// Sequencer driving an external 4-bit adder one nibble per cycle, LSB first.
// Optional macro MNA_OVF_DETECT_EN adds a two's-complement overflow flag (ovf).
module multi_nibble_add_seq
    import mna_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [NIBBLE_W*NIBBLES-1:0] result,
    output logic                      cout,
    output logic [NIBBLE_W-1:0]       add_a,
    output logic [NIBBLE_W-1:0]       add_b,
    output logic                      add_cin,
    input  logic [NIBBLE_W-1:0]       add_sum,
    input  logic                      add_cout
`ifdef MNA_OVF_DETECT_EN
    ,
    output logic                      ovf
`endif
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_w(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [W-1:0]  result_q, result_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          in_run;
    logic          finish;

    assign in_run = (state_q == RUN);
    assign finish = in_run && (idx_q == LAST);

    // Next-state and datapath update for the nibble sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        idx_d    = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                sum_d   = {add_sum, sum_q[W-1:NIBBLE_W]};
                carry_d = add_cout;
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                idx_d   = idx_q + 1'b1;
                if (finish) begin
                    state_d  = DONE;
                    result_d = sum_d;
                    cout_d   = add_cout;
                    idx_d    = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            idx_q    <= idx_d;
        end
    end

    // Adder drive is live only in RUN so it idles at zero otherwise.
    always_comb begin
        busy    = in_run;
        done    = (state_q == DONE);
        result  = result_q;
        cout    = cout_q;
        add_a   = in_run ? a_q[NIBBLE_W-1:0] : '0;
        add_b   = in_run ? b_q[NIBBLE_W-1:0] : '0;
        add_cin = in_run ? carry_q : 1'b0;
    end

`ifdef MNA_OVF_DETECT_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    // Operand sign bits are kept aside since the operand registers shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                a_msb_q <= op_a[W-1];
                b_msb_q <= op_b[W-1];
            end
            if (finish) begin
                ovf_q <= (a_msb_q == b_msb_q) &&
                         (add_sum[NIBBLE_W-1] != a_msb_q);
            end
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_multi_nibble_add_seq.sv
// Randomized self-checking bench for multi_nibble_add_seq.
// Models the external adder and checks against whole-word arithmetic.
module tb_multi_nibble_add_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
`ifdef MNA_OVF_DETECT_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_res;
    logic         exp_cout;
    logic         exp_ovf;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    multi_nibble_add_seq #(.NIBBLES(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
`ifdef MNA_OVF_DETECT_EN
        ,
        .ovf      (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic carry_into(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic c, input int i);
        logic [63:0] m;
        logic [63:0] s;
        m = (64'd1 << (4 * i)) - 64'd1;
        s = ({48'd0, a} & m) + ({48'd0, b} & m) + {63'd0, c};
        return s[4 * i];
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_cout"}, cout, exp_cout);
        chk({tag, "_adda"}, add_a, 0);
        chk({tag, "_addb"}, add_b, 0);
        chk({tag, "_addc"}, add_cin, 0);
`ifdef MNA_OVF_DETECT_EN
        chk({tag, "_ovf"}, ovf, exp_ovf);
`endif
    endtask

    // pulse_at: RUN cycle index for a spurious start, N = during DONE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input int pulse_at);
        logic [W:0] full;
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        cin   = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            start = (i == pulse_at);
            op_a  = W'($urandom);
            op_b  = W'($urandom);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_adda", add_a, (a >> (4 * i)) & 4'hF);
            chk("run_addb", add_b, (b >> (4 * i)) & 4'hF);
            chk("run_addc", add_cin, carry_into(a, b, c, i));
            chk("run_hold_res", result, exp_res);
            chk("run_hold_cout", cout, exp_cout);
        end
        full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        exp_res  = full[W-1:0];
        exp_cout = full[W];
        exp_ovf  = (a[W-1] == b[W-1]) && (exp_res[W-1] != a[W-1]);
        @(negedge clk);
        start = (pulse_at >= N);
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_res", result, exp_res);
        chk("fin_cout", cout, exp_cout);
        chk("fin_adda", add_a, 0);
`ifdef MNA_OVF_DETECT_EN
        chk("fin_ovf", ovf, exp_ovf);
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        cin      = 1'b0;
        exp_res  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("rst");

        do_op(16'h1234, 16'h1111, 1'b0, -1);
        do_op(16'hFFFF, 16'h0001, 1'b0, -1);
        do_op(16'hFFFF, 16'h0000, 1'b1, -1);
        do_op(16'h0000, 16'h0000, 1'b0, -1);
        do_op(16'h00FF, 16'h0001, 1'b0, 1);
        do_op(16'hAAAA, 16'h5555, 1'b1, N);
        do_op(16'h1234, 16'h4321, 1'b0, -1);

        // abort mid-RUN with a synchronous reset
        @(negedge clk);
        start = 1'b1;
        op_a  = 16'h1234;
        op_b  = 16'h1111;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        exp_res  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            chk_quiet("abort");
        end
        do_op(16'h0F0F, 16'h0101, 1'b1, -1);

`ifdef MNA_OVF_DETECT_EN
        do_op(16'h7FFF, 16'h0001, 1'b0, -1);
        do_op(16'h8000, 16'h8000, 1'b0, -1);
        do_op(16'h4000, 16'h3FFF, 1'b0, -1);
`endif

        for (int k = 0; k < 24; k++) begin
            int gap;
            do_op(W'($urandom), W'($urandom), 1'($urandom),
                  int'($urandom_range(0, N + 2)));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk_quiet("gap");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
